// File: rtl/mul16_seq_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// WIDTH iterations per operation, with a start/busy/done handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; operands latched on the accepting edge
//   S_RUN  | one add-and-shift iteration per clock, WIDTH iterations
//   S_DONE | product valid, done high for this single cycle
module mul16_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH-1:0]     pp;
    logic [WIDTH:0]       sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    // The carry out of the add lands in the accumulator MSB after the shift,
    // so it is retained without a separate flop.
    always_comb begin
        pp  = a_q & {WIDTH{q_q[0]}};
        sum = {1'b0, p_q} + {1'b0, pp};

        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prod_d  = prod_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    q_d     = b;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                p_d   = sum[WIDTH:1];
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    prod_d  = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Directed bench for mul16_seq_ctrl: hand-computed products, latency,
// handshake timing, mid-run reset and back-to-back throughput.
module tb_mul16_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_cmp = 0;
    int n_err = 0;

    mul16_seq_ctrl #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation; disturb pulses start and scrambles a/b during RUN.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] exp, input string tag, input bit disturb);
        logic [31:0] prev;
        int          cyc;
        bit          held;
        prev  = product;
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " busy after accept"}, busy, 1);
        check({tag, " done after accept"}, done, 0);
        cyc  = 0;
        held = 1;
        while (!done && cyc < 40) begin
            if (product !== prev) held = 0;
            if (disturb) begin
                start = (cyc == 3) || (cyc == 9);
                a     = (cyc == 3) ? 16'd7 : 16'($urandom);
                b     = (cyc == 3) ? 16'd7 : 16'($urandom);
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, cyc, 16);
        check({tag, " product"}, product, exp);
        check({tag, " product held in run"}, held, 1);
        step();
        check({tag, " done single cycle"}, done, 0);
        check({tag, " busy low after done"}, busy, 0);
        step();
        check({tag, " no queued start"}, busy, 0);
    endtask

    initial begin
        int dones;
        int last_done;
        int low_run;
        int cyc;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
        rst_n = 1'b1;
        step();

        run_op(16'd3,    16'd5,    32'h0000_000F, "3x5",       0);
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "ffffxffff", 0);
        run_op(16'h8000, 16'h0002, 32'h0001_0000, "8000x2",    0);
        run_op(16'h1234, 16'h0000, 32'h0000_0000, "1234x0",    0);
        run_op(16'h0000, 16'hABCD, 32'h0000_0000, "0xabcd",    0);
        run_op(16'd7,    16'd7,    32'h0000_0031, "7x7 dist",  1);

        // Abort in the middle of RUN; reset must clear outputs without a clock edge.
        a     = 16'h1234;
        b     = 16'h5678;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        check("async rst product", product, 0);
        #3 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) dones++;
        end
        check("no done after abort", dones, 0);
        check("idle after abort", busy, 0);
        run_op(16'd2, 16'd3, 32'h0000_0006, "2x3", 0);

        // Start held high: one result every 18 cycles, one idle cycle between.
        a         = 16'h00FF;
        b         = 16'h0101;
        start     = 1'b1;
        dones     = 0;
        last_done = -1;
        low_run   = 0;
        cyc       = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            cyc++;
            if (done) begin
                dones++;
                check("b2b product", product, 32'h0000_FFFF);
                if (last_done >= 0) check("b2b interval", cyc - last_done, 18);
                last_done = cyc;
            end
            if (!busy) low_run++;
            else if (low_run > 0) begin
                check("b2b busy low width", low_run, 1);
                low_run = 0;
            end
        end
        start = 1'b0;
        check("b2b done count", dones, 3);
        cyc = 0;
        while (busy && cyc < 40) begin
            step();
            cyc++;
        end
        check("b2b drain", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
